// File: rtl/bnn_stream_loader.sv
// Host-side serial loader for the BNN: streams weight/pixel bytes LSB-first onto the
// serial pins, waits out the run-mode settle time, then captures the answer digit.
module bnn_stream_loader #(
  parameter int N_WEIGHTS   = 8192,
  parameter int N_PIXELS    = 784,
  parameter int RESULT_WAIT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       load_wts,
  input  logic       abort,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       mode_out,
  output logic       weight_out,
  output logic       pixel_out,
  input  logic [3:0] answer_in,
  output logic       busy,
  output logic       done,
  output logic [3:0] answer,
  output logic       err
);

  localparam int NMAX = (N_WEIGHTS > N_PIXELS) ? N_WEIGHTS : N_PIXELS;
  localparam int CW   = $clog2(NMAX + 1);
  localparam int WW   = $clog2(RESULT_WAIT + 1);

  typedef enum logic [2:0] {IDLE, WLOAD, PLOAD, RUN, CAPTURE} state_e;

  state_e          state_q, state_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [3:0]      bits_left_q, bits_left_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [3:0]      answer_q, answer_d;
  logic            err_q, err_d;

  logic            in_load, emit, accept, last_bit;
  logic [CW-1:0]   phase_n, rem, rem_after;

  // A freshly loaded byte never holds more useful bits than the phase still needs, so
  // the surplus tail of a partial final byte is dropped at load time.
  function automatic logic [3:0] clip8(input int n);
    return (n >= 8) ? 4'd8 : n[3:0];
  endfunction

  assign in_load   = (state_q == WLOAD) || (state_q == PLOAD);
  assign emit      = in_load && (bits_left_q != 4'd0);
  assign phase_n   = (state_q == WLOAD) ? CW'(N_WEIGHTS) : CW'(N_PIXELS);
  assign rem       = phase_n - bit_cnt_q;
  assign rem_after = rem - CW'(emit);
  assign last_bit  = emit && (rem == CW'(1));

  // In WLOAD a fetch is always useful: once the weights run out it becomes the first
  // pixel byte, which lets the last weight bit and first pixel bit sit back to back.
  assign s_ready = in_load && (bits_left_q <= 4'd1) &&
                   ((state_q == WLOAD) || (rem > CW'(bits_left_q)));
  assign accept  = s_valid && s_ready;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    state_d     = state_q;
    shreg_d     = shreg_q;
    bits_left_d = bits_left_q;
    bit_cnt_d   = bit_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    answer_d    = answer_q;
    err_d       = err_q;

    unique case (state_q)
      IDLE: begin
        if (start) state_d = load_wts ? WLOAD : PLOAD;
      end
      WLOAD, PLOAD: begin
        if (emit) begin
          shreg_d     = {1'b0, shreg_q[7:1]};
          bits_left_d = bits_left_q - 4'd1;
          bit_cnt_d   = bit_cnt_q + CW'(1);
        end
        if (accept) begin
          shreg_d     = s_data;
          bits_left_d = (rem_after != '0) ? clip8(int'(rem_after)) : clip8(N_PIXELS);
        end
        if (last_bit) begin
          bit_cnt_d = '0;
          state_d   = (state_q == WLOAD) ? PLOAD : RUN;
        end
      end
      RUN: begin
        if (wait_cnt_q == WW'(RESULT_WAIT - 1)) begin
          wait_cnt_d = '0;
          state_d    = CAPTURE;
        end else begin
          wait_cnt_d = wait_cnt_q + WW'(1);
        end
      end
      CAPTURE: begin
        answer_d = answer_in;
        err_d    = (answer_in > 4'd9);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d     = IDLE;
      shreg_d     = '0;
      bits_left_d = '0;
      bit_cnt_d   = '0;
      wait_cnt_d  = '0;
      answer_d    = answer_q;
      err_d       = err_q;
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bits_left_q <= '0;
      bit_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      answer_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bits_left_q <= bits_left_d;
      bit_cnt_q   <= bit_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      answer_q    <= answer_d;
      err_q       <= err_d;
    end
  end

  assign mode_out   = !emit;
  assign weight_out = emit && (state_q == WLOAD) && shreg_q[0];
  assign pixel_out  = emit && (state_q == PLOAD) && shreg_q[0];
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == CAPTURE);
  assign answer     = done ? answer_in : answer_q;
  assign err        = done ? (answer_in > 4'd9) : err_q;

endmodule

// File: tb/tb_bnn_stream_loader.sv
// Randomised self-checking bench: the expected serial stream is rebuilt from the byte
// list by bit arithmetic and compared with what appears on the pins.
module tb_bnn_stream_loader;

  localparam int NW = 12;
  localparam int NP = 16;
  localparam int RW = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, load_wts, abort, s_valid;
  logic [7:0] s_data;
  logic       s_ready, mode_out, weight_out, pixel_out, busy, done, err;
  logic [3:0] answer_in, answer;

  int checks   = 0;
  int failures = 0;

  bnn_stream_loader #(.N_WEIGHTS(NW), .N_PIXELS(NP), .RESULT_WAIT(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .load_wts(load_wts), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .mode_out(mode_out),
    .weight_out(weight_out), .pixel_out(pixel_out), .answer_in(answer_in),
    .busy(busy), .done(done), .answer(answer), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // gap_mode: 0 = always valid, 1 = one 3-cycle valid drop mid-pixel, 2 = random gaps.
  task automatic run_seq(input string tag, input bit lw, input bit fixed, input int gap_mode,
                         input logic [3:0] ans, input int abort_at);
    logic [7:0] bytes[$];
    logic [7:0] b;
    logic [1:0] exp_s[$];
    logic [1:0] obs[$];
    int nwb, npb, nw_eff, cyc, first_emit, last_emit, done_cyc, done_cnt;
    int pix_seen, drop_left, abort_cyc, bad_idle, bit_err;
    bit dropped, aborted, v;
    logic [3:0] got_ans;
    logic       got_err;

    nw_eff = lw ? NW : 0;
    nwb = (nw_eff + 7) / 8;
    npb = (NP + 7) / 8;
    for (int i = 0; i < nwb + npb; i++) begin
      if (fixed) begin
        case (i)
          0: b = 8'hA5;
          1: b = 8'h0F;
          2: b = 8'h3C;
          default: b = 8'hC3;
        endcase
      end else begin
        b = 8'($urandom);
      end
      bytes.push_back(b);
    end
    for (int i = 0; i < nw_eff; i++) exp_s.push_back({bytes[i/8][i%8], 1'b0});
    for (int i = 0; i < NP; i++)     exp_s.push_back({1'b0, bytes[nwb + i/8][i%8]});

    cyc = 0; first_emit = -1; last_emit = -1; done_cyc = -1; done_cnt = 0;
    pix_seen = 0; drop_left = 0; abort_cyc = -1; bad_idle = 0;
    dropped = 0; aborted = 0; got_ans = '0; got_err = 1'b0;

    @(negedge clk);
    answer_in = ans; load_wts = lw; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < 400) begin
      if (!mode_out) begin
        obs.push_back({weight_out, pixel_out});
        if (first_emit < 0) first_emit = cyc;
        last_emit = cyc;
        if (obs.size() > nw_eff) pix_seen++;
      end else if (weight_out || pixel_out) begin
        bad_idle++;
      end
      if (!busy && !mode_out) bad_idle++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc; got_ans = answer; got_err = err;
        end
      end
      if (done_cyc >= 0 && cyc == done_cyc + 2) begin
        check({tag, "_answer_held"}, answer, ans);
        check({tag, "_done_width"}, done_cnt, 1);
        break;
      end
      if (aborted && cyc == abort_cyc + 1) begin
        check({tag, "_abort_busy"}, busy, 0);
        check({tag, "_abort_mode"}, mode_out, 1);
        check({tag, "_abort_ready"}, s_ready, 0);
        check({tag, "_abort_data"}, {weight_out, pixel_out}, 0);
      end
      if (aborted && cyc == abort_cyc + 20) break;

      abort = 1'b0;
      if (abort_at > 0 && !aborted && !mode_out && pix_seen == abort_at) begin
        abort = 1'b1; aborted = 1'b1; abort_cyc = cyc;
      end

      case (gap_mode)
        0: v = 1'b1;
        1: begin
          if (drop_left > 0) begin
            v = 1'b0; drop_left--;
          end else if (!dropped && pix_seen > 0 && s_ready) begin
            v = 1'b0; dropped = 1'b1; drop_left = 2;
          end else begin
            v = 1'b1;
          end
        end
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      v = v && (bytes.size() > 0) && !aborted;
      s_valid = v;
      s_data  = v ? bytes[0] : 8'($urandom);
      if (v && s_ready) void'(bytes.pop_front());
      // Stray starts while busy must be ignored.
      start    = busy && !done && !aborted && ($urandom_range(0, 7) == 0);
      load_wts = 1'($urandom);
      @(negedge clk);
      cyc++;
    end
    s_valid = 1'b0; start = 1'b0; abort = 1'b0;

    check({tag, "_idle_outputs"}, bad_idle, 0);
    if (abort_at > 0) begin
      check({tag, "_abort_seen"}, aborted, 1);
      check({tag, "_abort_no_done"}, done_cnt, 0);
    end else begin
      bit_err = 0;
      for (int i = 0; i < obs.size() && i < exp_s.size(); i++)
        if (obs[i] !== exp_s[i]) bit_err++;
      check({tag, "_bit_count"}, obs.size(), exp_s.size());
      check({tag, "_bit_errors"}, bit_err, 0);
      check({tag, "_done_seen"}, (done_cyc >= 0), 1);
      check({tag, "_done_latency"}, done_cyc - last_emit, RW + 1);
      check({tag, "_answer"}, got_ans, ans);
      check({tag, "_err"}, got_err, (ans > 4'd9));
      check({tag, "_bytes_used"}, bytes.size(), 0);
      if (gap_mode == 0) check({tag, "_contiguous"}, last_emit - first_emit + 1, exp_s.size());
      if (gap_mode == 1) check({tag, "_bubbles"}, last_emit - first_emit + 1, exp_s.size() + 3);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; load_wts = 1'b0; abort = 1'b0;
    s_valid = 1'b0; s_data = '0; answer_in = '0;
    #12;
    check("rst_ready", s_ready, 0);
    check("rst_mode", mode_out, 1);
    check("rst_data", {weight_out, pixel_out}, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_answer", {answer, err}, 0);
    @(negedge clk);
    rst = 1'b0;

    run_seq("fixed",    1'b1, 1'b1, 0, 4'd3, 0);
    run_seq("drop",     1'b1, 1'b1, 1, 4'd5, 0);
    run_seq("pix_only", 1'b0, 1'b0, 0, 4'd7, 0);
    run_seq("err_c",    1'b1, 1'b0, 0, 4'hC, 0);
    run_seq("abort",    1'b1, 1'b0, 0, 4'd2, 5);
    run_seq("post_abt", 1'b1, 1'b0, 0, 4'd9, 0);
    for (int r = 0; r < 4; r++)
      run_seq($sformatf("rand%0d", r), 1'($urandom), 1'b0, 2, 4'($urandom), 0);

    // Asynchronous reset in the middle of a weight load.
    @(negedge clk);
    answer_in = 4'd6; load_wts = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; s_valid = 1'b1; s_data = 8'hFF;
    repeat (3) @(negedge clk);
    check("pre_rst_weight", {busy, mode_out, weight_out}, 3'b101);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_mode", mode_out, 1);
    check("arst_ready", s_ready, 0);
    check("arst_data", {weight_out, pixel_out}, 0);
    check("arst_answer", {answer, err, done}, 0);
    @(negedge clk);
    s_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {busy, mode_out}, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
